// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch unit drives the request side (master), memory answers (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
// One outstanding instruction request at a time; decode-stage redirects
// (jump over taken branch) squash the wrong-path fetch, no delay slot.
// A one-entry hold buffer absorbs a response that lands while decode is stalled.
// Optional feature: define FETCH_HALT_EN to stop fetching once HALT_WORD
// enters IF/ID; without it HALT_WORD is an ordinary instruction.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
`ifdef FETCH_HALT_EN
  ,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stallD,
  input  logic         pc_srcD,
  input  logic [31:0]  branch_targetD,
  input  logic         jumpD,
  input  logic [31:0]  jump_targetD,
  fetch_unit_if.master imem,
  output logic [31:0]  pcF,
  output logic [31:0]  instrD,
  output logic [31:0]  pc_plus4D,
  output logic         validD,
  output logic         haltedF
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DROP = 2'd1,
    ST_HALT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DROP = 2'd1
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pendingPc_q, pendingPc_d;
  logic        holdValid_q, holdValid_d;
  logic [31:0] holdInstr_q, holdInstr_d;
  logic [31:0] holdPc4_q, holdPc4_d;
  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pc4D_q, pc4D_d;
  logic        validD_q, validD_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcPlus4;
  logic        reqActive;
  logic        respValid;

  // A redirect only counts for a real, non-stalled decode instruction; jump wins.
  assign redirect  = (jumpD | pc_srcD) & validD_q & ~stallD;
  assign target    = jumpD ? jump_targetD : branch_targetD;
  assign pcPlus4   = pc_q + 32'd4;
  assign respValid = imem.imem_valid & reqActive;

  // Request is held off in reset, while the hold buffer is occupied, and when halted.
  always_comb begin
    reqActive = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_REQ:  reqActive = ~holdValid_q;
        ST_DROP: reqActive = 1'b1;
        default: reqActive = 1'b0;
      endcase
    end
  end

  assign imem.imem_req  = reqActive;
  assign imem.imem_addr = pc_q;

  // Next-state logic: PC advance, redirect handling, hold buffer and IF/ID loading.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pendingPc_d = pendingPc_q;
    holdValid_d = holdValid_q;
    holdInstr_d = holdInstr_q;
    holdPc4_d   = holdPc4_q;
    instrD_d    = instrD_q;
    pc4D_d      = pc4D_q;
    validD_d    = validD_q;

    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          holdValid_d = 1'b0;
          instrD_d    = '0;
          pc4D_d      = '0;
          validD_d    = 1'b0;
          if (reqActive && !respValid) begin
            pendingPc_d = target;
            state_d     = ST_DROP;
          end else begin
            pc_d = target;
          end
        end else if (!stallD) begin
          if (holdValid_q) begin
            instrD_d    = holdInstr_q;
            pc4D_d      = holdPc4_q;
            validD_d    = 1'b1;
            holdValid_d = 1'b0;
`ifdef FETCH_HALT_EN
            if (holdInstr_q == HALT_WORD) state_d = ST_HALT;
`endif
          end else if (respValid) begin
            instrD_d = imem.imem_rdata;
            pc4D_d   = pcPlus4;
            validD_d = 1'b1;
            pc_d     = pcPlus4;
`ifdef FETCH_HALT_EN
            if (imem.imem_rdata == HALT_WORD) state_d = ST_HALT;
`endif
          end else begin
            instrD_d = '0;
            pc4D_d   = '0;
            validD_d = 1'b0;
          end
        end else if (respValid) begin
          holdValid_d = 1'b1;
          holdInstr_d = imem.imem_rdata;
          holdPc4_d   = pcPlus4;
          pc_d        = pcPlus4;
        end
      end
      ST_DROP: begin
        instrD_d = '0;
        pc4D_d   = '0;
        validD_d = 1'b0;
        if (respValid) begin
          pc_d    = pendingPc_q;
          state_d = ST_REQ;
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: begin
        if (!stallD) begin
          instrD_d = '0;
          pc4D_d   = '0;
          validD_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State register with synchronous reset; a stale response during reset is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      pendingPc_q <= '0;
      holdValid_q <= 1'b0;
      holdInstr_q <= '0;
      holdPc4_q   <= '0;
      instrD_q    <= '0;
      pc4D_q      <= '0;
      validD_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pendingPc_q <= pendingPc_d;
      holdValid_q <= holdValid_d;
      holdInstr_q <= holdInstr_d;
      holdPc4_q   <= holdPc4_d;
      instrD_q    <= instrD_d;
      pc4D_q      <= pc4D_d;
      validD_q    <= validD_d;
    end
  end

  assign pcF       = pc_q;
  assign instrD    = instrD_q;
  assign pc_plus4D = pc4D_q;
  assign validD    = validD_q;

`ifdef FETCH_HALT_EN
  assign haltedF = (state_q == ST_HALT);
`else
  assign haltedF = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a program-order stream model of what decode should see.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallD, pc_srcD, jumpD;
  logic [31:0] branch_targetD, jump_targetD;
  logic [31:0] pcF, instrD, pc_plus4D;
  logic        validD, haltedF;

  int checks = 0;
  int errors = 0;

  // Memory model controls.
  logic [1:0]  memLat = 2'd0;
  bit          randLat = 1'b0;
  logic [31:0] xorKey = 32'h0;
  bit          overrideEn = 1'b0;
  logic [31:0] overrideAddr = 32'h0;
  logic [31:0] overrideWord = 32'h0;
  logic [2:0]  waitCnt;
  logic [1:0]  curLat;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stallD         (stallD),
    .pc_srcD        (pc_srcD),
    .branch_targetD (branch_targetD),
    .jumpD          (jumpD),
    .jump_targetD   (jump_targetD),
    .imem           (bus),
    .pcF            (pcF),
    .instrD         (instrD),
    .pc_plus4D      (pc_plus4D),
    .validD         (validD),
    .haltedF        (haltedF)
  );

  always #5 clk = ~clk;

  // Instruction memory: word = address ^ key (or an override), latency in cycles.
  assign bus.imem_valid = bus.imem_req && (waitCnt >= {1'b0, curLat});
  assign bus.imem_rdata = (overrideEn && bus.imem_addr == overrideAddr) ? overrideWord
                                                                         : (bus.imem_addr ^ xorKey);

  always @(posedge clk) begin
    if (reset) begin
      waitCnt <= 3'd0;
      curLat  <= memLat;
    end else if (bus.imem_req && bus.imem_valid) begin
      waitCnt <= 3'd0;
      curLat  <= randLat ? 2'($urandom_range(0, 3)) : memLat;
    end else if (bus.imem_req) begin
      waitCnt <= waitCnt + 3'd1;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    reset = 1'b1; stallD = 1'b0; pc_srcD = 1'b0; jumpD = 1'b0;
    branch_targetD = 32'h0; jump_targetD = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitInstr(input logic [31:0] want, input int budget, output bit found);
    found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (validD === 1'b1 && instrD === want) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stallD = 1'b0; pc_srcD = 1'b0; jumpD = 1'b0;
    branch_targetD = 32'h0; jump_targetD = 32'h0;
    memLat = 2'd0; randLat = 1'b0; xorKey = 32'h0; overrideEn = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %0b want 0", bus.imem_req); end
    @(negedge clk);
    checks++; if (pcF !== RESET_PC) begin errors++; $display("[TB] FAIL reset_pcF got %h want %h", pcF, RESET_PC); end
    checks++; if (instrD !== 32'h0) begin errors++; $display("[TB] FAIL reset_instrD got %h want 0", instrD); end
    checks++; if (pc_plus4D !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_plus4D got %h want 0", pc_plus4D); end
    checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL reset_validD got %b want 0", validD); end
    checks++; if (haltedF !== 1'b0) begin errors++; $display("[TB] FAIL reset_haltedF got %b want 0", haltedF); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    memLat = 2'd0; randLat = 1'b0; xorKey = 32'h0;
    doReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (validD !== 1'b1 || instrD !== 32'(i * 4) || pc_plus4D !== 32'(i * 4 + 4)) begin
        errors++; $display("[TB] FAIL seq_%0d got v=%b instr=%h pc4=%h want v=1 instr=%h pc4=%h",
                           i, validD, instrD, pc_plus4D, 32'(i * 4), 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_branch();
    bit found;
    memLat = 2'd0; randLat = 1'b0; xorKey = 32'h0;
    doReset();
    waitInstr(32'h8, 10, found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL branch_reach8 got timeout want instr 8"); end
    pc_srcD = 1'b1; branch_targetD = 32'h40;
    @(negedge clk);
    pc_srcD = 1'b0;
    checks++; if (validD !== 1'b0 || instrD !== 32'h0 || pc_plus4D !== 32'h0) begin
      errors++; $display("[TB] FAIL branch_bubble got v=%b instr=%h pc4=%h want 0/0/0", validD, instrD, pc_plus4D);
    end
    checks++; if (pcF !== 32'h40) begin errors++; $display("[TB] FAIL branch_pcF got %h want 40", pcF); end
    @(negedge clk);
    checks++; if (validD !== 1'b1 || instrD !== 32'h40 || pc_plus4D !== 32'h44) begin
      errors++; $display("[TB] FAIL branch_t0 got v=%b instr=%h pc4=%h want 1/40/44", validD, instrD, pc_plus4D);
    end
    @(negedge clk);
    checks++; if (validD !== 1'b1 || instrD !== 32'h44) begin
      errors++; $display("[TB] FAIL branch_t1 got v=%b instr=%h want 1/44", validD, instrD);
    end
  endtask

  task automatic test_drop();
    bit found;
    memLat = 2'd2; randLat = 1'b0; xorKey = 32'h0;
    doReset();
    waitInstr(32'hC, 40, found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL drop_reachC got timeout want instr C"); end
    checks++; if (bus.imem_valid !== 1'b0 || bus.imem_addr !== 32'h10) begin
      errors++; $display("[TB] FAIL drop_waiting got valid=%b addr=%h want 0/10", bus.imem_valid, bus.imem_addr);
    end
    pc_srcD = 1'b1; branch_targetD = 32'h100;
    @(negedge clk);
    pc_srcD = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || validD !== 1'b0) begin
        errors++; $display("[TB] FAIL drop_hold_%0d got req=%b addr=%h v=%b want 1/10/0", i, bus.imem_req, bus.imem_addr, validD);
      end
      @(negedge clk);
    end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || validD !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_newreq got req=%b addr=%h v=%b want 1/100/0", bus.imem_req, bus.imem_addr, validD);
    end
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (validD === 1'b1) found = 1'b1;
    end
    checks++; if (!found || instrD !== 32'h100 || pc_plus4D !== 32'h104) begin
      errors++; $display("[TB] FAIL drop_first got found=%b instr=%h pc4=%h want 1/100/104", found, instrD, pc_plus4D);
    end
    // Enter DROP again, then reset in the middle of it.
    waitInstr(32'h104, 10, found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL drop_reach104 got timeout want instr 104"); end
    jumpD = 1'b1; jump_targetD = 32'h500;
    @(negedge clk);
    jumpD = 1'b0;
    checks++; if (bus.imem_addr !== 32'h108 || bus.imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL drop2_hold got req=%b addr=%h want 1/108", bus.imem_req, bus.imem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (pcF !== RESET_PC || validD !== 1'b0 || instrD !== 32'h0) begin
      errors++; $display("[TB] FAIL drop_reset got pcF=%h v=%b instr=%h want %h/0/0", pcF, validD, instrD, RESET_PC);
    end
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (validD === 1'b1) found = 1'b1;
    end
    checks++; if (!found || instrD !== RESET_PC) begin
      errors++; $display("[TB] FAIL drop_reset_first got found=%b instr=%h want 1/%h", found, instrD, RESET_PC);
    end
  endtask

  task automatic test_stall();
    bit found;
    memLat = 2'd0; randLat = 1'b0; xorKey = 32'h0;
    doReset();
    waitInstr(32'h8, 10, found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL stall_reach8 got timeout want instr 8"); end
    stallD = 1'b1;
    @(negedge clk);
    checks++; if (instrD !== 32'h8 || validD !== 1'b1 || bus.imem_req !== 1'b0 || pcF !== 32'h10) begin
      errors++; $display("[TB] FAIL stall_c1 got instr=%h v=%b req=%b pcF=%h want 8/1/0/10", instrD, validD, bus.imem_req, pcF);
    end
    @(negedge clk);
    checks++; if (instrD !== 32'h8 || validD !== 1'b1 || bus.imem_req !== 1'b0 || pcF !== 32'h10) begin
      errors++; $display("[TB] FAIL stall_c2 got instr=%h v=%b req=%b pcF=%h want 8/1/0/10", instrD, validD, bus.imem_req, pcF);
    end
    stallD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (validD !== 1'b1 || instrD !== 32'(12 + 4 * i) || pc_plus4D !== 32'(16 + 4 * i)) begin
        errors++; $display("[TB] FAIL stall_drain_%0d got v=%b instr=%h pc4=%h want 1/%h/%h",
                           i, validD, instrD, pc_plus4D, 32'(12 + 4 * i), 32'(16 + 4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    bit found;
    memLat = 2'd0; randLat = 1'b0; xorKey = 32'h0;
    doReset();
    waitInstr(RESET_PC, 10, found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL wrap_start got timeout want first instr"); end
    jumpD = 1'b1; jump_targetD = 32'hFFFF_FFFC;
    pc_srcD = 1'b1; branch_targetD = 32'h300;
    @(negedge clk);
    jumpD = 1'b0; pc_srcD = 1'b0;
    checks++; if (pcF !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_jump_prio got pcF=%h want fffffffc", pcF); end
    @(negedge clk);
    checks++; if (validD !== 1'b1 || instrD !== 32'hFFFF_FFFC || pc_plus4D !== 32'h0 || pcF !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_top got v=%b instr=%h pc4=%h pcF=%h want 1/fffffffc/0/0", validD, instrD, pc_plus4D, pcF);
    end
    @(negedge clk);
    checks++; if (validD !== 1'b1 || instrD !== 32'h0 || pc_plus4D !== 32'h4) begin
      errors++; $display("[TB] FAIL wrap_next got v=%b instr=%h pc4=%h want 1/0/4", validD, instrD, pc_plus4D);
    end
  endtask

  task automatic test_halt_word();
    bit found;
    memLat = 2'd0; randLat = 1'b0; xorKey = 32'h0;
    overrideEn = 1'b1; overrideAddr = 32'h8; overrideWord = 32'hFFFF_FFFF;
    doReset();
    waitInstr(32'hFFFF_FFFF, 10, found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL halt_reach got timeout want instr ffffffff"); end
`ifdef FETCH_HALT_EN
    checks++; if (haltedF !== 1'b1 || bus.imem_req !== 1'b0 || pcF !== 32'hC) begin
      errors++; $display("[TB] FAIL halt_enter got halted=%b req=%b pcF=%h want 1/0/c", haltedF, bus.imem_req, pcF);
    end
    pc_srcD = 1'b1; branch_targetD = 32'h80;
    repeat (3) @(negedge clk);
    pc_srcD = 1'b0;
    checks++; if (haltedF !== 1'b1 || bus.imem_req !== 1'b0 || pcF !== 32'hC || validD !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_stay got halted=%b req=%b pcF=%h v=%b want 1/0/c/0", haltedF, bus.imem_req, pcF, validD);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (haltedF !== 1'b0 || pcF !== RESET_PC) begin
      errors++; $display("[TB] FAIL halt_reset got halted=%b pcF=%h want 0/%h", haltedF, pcF, RESET_PC);
    end
    @(negedge clk);
    checks++; if (validD !== 1'b1 || instrD !== RESET_PC) begin
      errors++; $display("[TB] FAIL halt_restart got v=%b instr=%h want 1/%h", validD, instrD, RESET_PC);
    end
`else
    checks++; if (haltedF !== 1'b0 || pcF !== 32'hC || bus.imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_ordinary got halted=%b pcF=%h req=%b want 0/c/1", haltedF, pcF, bus.imem_req);
    end
    @(negedge clk);
    checks++; if (validD !== 1'b1 || instrD !== 32'hC || haltedF !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_ordinary_next got v=%b instr=%h halted=%b want 1/c/0", validD, instrD, haltedF);
    end
`endif
    overrideEn = 1'b0;
  endtask

  // Randomized run: decode must see the program-order stream implied by redirects.
  task automatic test_random();
    logic [31:0] expectPc;
    logic [31:0] prevInstr, prevPc4, prevAddr;
    logic        prevValid;
    bit          prevStall, prevPending;
    int          consumed;
    memLat = 2'd0; randLat = 1'b1; xorKey = $urandom & 32'hFFFF_FFFC;
    doReset();
    expectPc = RESET_PC; consumed = 0;
    prevStall = 1'b0; prevPending = 1'b0;
    prevInstr = '0; prevPc4 = '0; prevValid = 1'b0; prevAddr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prevPending) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prevAddr) begin
          errors++; $display("[TB] FAIL rnd_req_held cyc %0d got req=%b addr=%h want 1/%h", cyc, bus.imem_req, bus.imem_addr, prevAddr);
        end
      end
      if (prevStall) begin
        checks++; if (instrD !== prevInstr || pc_plus4D !== prevPc4 || validD !== prevValid) begin
          errors++; $display("[TB] FAIL rnd_stall_hold cyc %0d got %h/%h/%b want %h/%h/%b",
                             cyc, instrD, pc_plus4D, validD, prevInstr, prevPc4, prevValid);
        end
      end
      prevPending = bus.imem_req && !bus.imem_valid;
      prevAddr    = bus.imem_addr;
      prevInstr = instrD; prevPc4 = pc_plus4D; prevValid = validD;

      stallD  = ($urandom_range(0, 3) == 0);
      pc_srcD = ($urandom_range(0, 7) == 0);
      jumpD   = ($urandom_range(0, 11) == 0);
      branch_targetD = $urandom & 32'h0000_0FFC;
      jump_targetD   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_3FFC);
      prevStall = stallD;

      if (validD === 1'b1 && !stallD) begin
        checks++; if (instrD !== (expectPc ^ xorKey) || pc_plus4D !== expectPc + 32'd4) begin
          errors++; $display("[TB] FAIL rnd_stream cyc %0d got instr=%h pc4=%h want %h/%h",
                             cyc, instrD, pc_plus4D, expectPc ^ xorKey, expectPc + 32'd4);
        end
        consumed++;
        if (jumpD)        expectPc = jump_targetD;
        else if (pc_srcD) expectPc = branch_targetD;
        else              expectPc = expectPc + 32'd4;
      end
      @(negedge clk);
    end
    stallD = 1'b0; pc_srcD = 1'b0; jumpD = 1'b0; randLat = 1'b0;
    checks++; if (consumed < 300) begin
      errors++; $display("[TB] FAIL rnd_progress got %0d instructions want at least 300", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_drop();
    test_stall();
    test_wrap();
    test_halt_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
